// File: rtl/adpll_lock_detector.sv
// ----------------------------------------------------------------------------
// adpll_lock_detector
//
// Watches the signed phase error of an ADPLL at each rising edge of a
// (pre-synchronised) reference clock and decides whether the loop is locked.
// Lock is declared after LOCK_COUNT consecutive small errors and dropped after
// UNLOCK_COUNT consecutive large errors; errors between the two thresholds are
// ignored while locked (hysteresis). A missing reference for REF_TIMEOUT
// clocks moves the detector to REF_LOST.
//
// Ports:
//   fpga_clk_i    - single clock, all state on its rising edge
//   rst_n_i       - asynchronous active-low reset
//   enable_i      - detector enable, low forces IDLE
//   ref_i         - reference clock, synchronous to fpga_clk_i
//   error_i       - signed phase error, PDET_WIDTH bits
//   locked_o      - high while in LOCKED
//   state_o       - 00 IDLE, 01 ACQUIRE, 10 LOCKED, 11 REF_LOST
//   lock_lost_o   - one-cycle pulse when leaving LOCKED for ACQUIRE/REF_LOST
//   lock_time_o   - ref edges from enable to first lock, saturating
//   peak_error_o  - max |error| since last entry to LOCKED
// ----------------------------------------------------------------------------
module adpll_lock_detector #(
    parameter int unsigned PDET_WIDTH    = 8,
    parameter int unsigned LOCK_THRESH   = 4,
    parameter int unsigned UNLOCK_THRESH = 16,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned UNLOCK_COUNT  = 4,
    parameter int unsigned REF_TIMEOUT   = 1024
) (
    input  logic                  fpga_clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic                  ref_i,
    input  logic [PDET_WIDTH-1:0] error_i,
    output logic                  locked_o,
    output logic [1:0]            state_o,
    output logic                  lock_lost_o,
    output logic [15:0]           lock_time_o,
    output logic [PDET_WIDTH-2:0] peak_error_o
);

    localparam int unsigned AW     = PDET_WIDTH - 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned TMO_W  = $clog2(REF_TIMEOUT + 1);

    localparam logic [AW-1:0]     LOCK_TH   = AW'(LOCK_THRESH);
    localparam logic [AW-1:0]     UNLOCK_TH = AW'(UNLOCK_THRESH);
    localparam logic [GOOD_W-1:0] GOOD_TGT  = GOOD_W'(LOCK_COUNT);
    localparam logic [BAD_W-1:0]  BAD_TGT   = BAD_W'(UNLOCK_COUNT);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(REF_TIMEOUT);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAcquire = 2'b01,
        StLocked  = 2'b10,
        StRefLost = 2'b11
    } state_e;

    // Front end
    logic          ref_q, ref_d;
    logic          ref_armed_q, ref_armed_d;
    logic          sample_valid_q, sample_valid_d;
    logic [AW-1:0] abs_q, abs_d;
    logic          strobe;
    logic          is_min;
    logic [AW-1:0] neg_mag;
    logic [AW-1:0] err_abs;

    // FSM and counters
    state_e            state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [TMO_W-1:0]  tmo_inc;
    logic              timeout;
    logic              lock_seen_q, lock_seen_d;
    logic              lock_lost_q, lock_lost_d;
    logic [15:0]       lock_time_q, lock_time_d;
    logic [AW-1:0]     peak_q, peak_d;

    always_comb begin
        ref_d       = ref_i;
        // A strobe needs ref_i seen low since reset so a high ref at reset
        // release is not mistaken for an edge.
        ref_armed_d = ref_armed_q | ~ref_i;
        strobe      = ref_i & ~ref_q & ref_armed_q;

        // Most-negative input has no positive counterpart; clamp it.
        is_min  = error_i[AW] & ~(|error_i[AW-1:0]);
        neg_mag = ~error_i[AW-1:0] + 1'b1;
        if (is_min) begin
            err_abs = '1;
        end else if (error_i[AW]) begin
            err_abs = neg_mag;
        end else begin
            err_abs = error_i[AW-1:0];
        end

        sample_valid_d = strobe;
        abs_d          = strobe ? err_abs : abs_q;
    end

    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        bad_d       = bad_q;
        lock_seen_d = lock_seen_q;
        lock_lost_d = 1'b0;
        lock_time_d = lock_time_q;
        peak_d      = peak_q;

        tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        tmo_d   = sample_valid_q ? '0 : tmo_inc;
        timeout = ~sample_valid_q & (tmo_inc == TMO_MAX);

        if (!enable_i) begin
            state_d     = StIdle;
            good_d      = '0;
            bad_d       = '0;
            tmo_d       = '0;
            lock_seen_d = 1'b0;
            lock_time_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StAcquire;
                    good_d  = '0;
                    bad_d   = '0;
                    tmo_d   = '0;
                end
                StAcquire: begin
                    if (timeout) begin
                        state_d = StRefLost;
                        good_d  = '0;
                    end else if (sample_valid_q) begin
                        if (!lock_seen_q && lock_time_q != 16'hFFFF) begin
                            lock_time_d = lock_time_q + 16'd1;
                        end
                        if (abs_q <= LOCK_TH) begin
                            if (good_q + 1'b1 == GOOD_TGT) begin
                                state_d     = StLocked;
                                good_d      = '0;
                                bad_d       = '0;
                                lock_seen_d = 1'b1;
                                peak_d      = abs_q;
                            end else begin
                                good_d = good_q + 1'b1;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                end
                StLocked: begin
                    if (timeout) begin
                        state_d     = StRefLost;
                        lock_lost_d = 1'b1;
                        bad_d       = '0;
                    end else if (sample_valid_q) begin
                        peak_d = (abs_q > peak_q) ? abs_q : peak_q;
                        if (abs_q > UNLOCK_TH) begin
                            if (bad_q + 1'b1 == BAD_TGT) begin
                                state_d     = StAcquire;
                                lock_lost_d = 1'b1;
                                bad_d       = '0;
                                good_d      = '0;
                            end else begin
                                bad_d = bad_q + 1'b1;
                            end
                        end else begin
                            bad_d = '0;
                        end
                    end
                end
                StRefLost: begin
                    if (sample_valid_q) begin
                        state_d = StAcquire;
                        good_d  = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ref_q          <= 1'b0;
            ref_armed_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            abs_q          <= '0;
            state_q        <= StIdle;
            good_q         <= '0;
            bad_q          <= '0;
            tmo_q          <= '0;
            lock_seen_q    <= 1'b0;
            lock_lost_q    <= 1'b0;
            lock_time_q    <= '0;
            peak_q         <= '0;
        end else begin
            ref_q          <= ref_d;
            ref_armed_q    <= ref_armed_d;
            sample_valid_q <= sample_valid_d;
            abs_q          <= abs_d;
            state_q        <= state_d;
            good_q         <= good_d;
            bad_q          <= bad_d;
            tmo_q          <= tmo_d;
            lock_seen_q    <= lock_seen_d;
            lock_lost_q    <= lock_lost_d;
            lock_time_q    <= lock_time_d;
            peak_q         <= peak_d;
        end
    end

    assign locked_o     = (state_q == StLocked);
    assign state_o      = state_q;
    assign lock_lost_o  = lock_lost_q;
    assign lock_time_o  = lock_time_q;
    assign peak_error_o = peak_q;

endmodule

// File: tb/tb_adpll_lock_detector.sv
// ----------------------------------------------------------------------------
// tb_adpll_lock_detector
//
// Directed bench: a table of {error, ref periods, expected outputs} records
// drives acquire/lock/unlock behaviour, followed by hand-written sequences for
// lock latency, enable drop, reference timeout and asynchronous reset.
// Inputs change on the falling clock edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_adpll_lock_detector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        ref_in;
    logic [7:0]  err;
    logic        locked;
    logic [1:0]  state;
    logic        lock_lost;
    logic [15:0] lock_time;
    logic [6:0]  peak;

    int checks = 0;
    int errors = 0;
    int lost_cnt = 0;

    always #5 clk = ~clk;

    adpll_lock_detector #(
        .PDET_WIDTH   (8),
        .LOCK_THRESH  (4),
        .UNLOCK_THRESH(16),
        .LOCK_COUNT   (16),
        .UNLOCK_COUNT (4),
        .REF_TIMEOUT  (1024)
    ) dut (
        .fpga_clk_i  (clk),
        .rst_n_i     (rst_n),
        .enable_i    (enable),
        .ref_i       (ref_in),
        .error_i     (err),
        .locked_o    (locked),
        .state_o     (state),
        .lock_lost_o (lock_lost),
        .lock_time_o (lock_time),
        .peak_error_o(peak)
    );

    // Count lock_lost pulses; a one-cycle pulse is seen at exactly one negedge.
    always @(negedge clk) begin
        if (lock_lost === 1'b1) lost_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One ref period: 4 clocks low, 4 clocks high, error held throughout.
    task automatic run_periods(input logic [7:0] e, input int n);
        for (int i = 0; i < n; i++) begin
            err    = e;
            ref_in = 1'b0;
            repeat (4) @(negedge clk);
            ref_in = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] e;
        int         n;
        int         st;
        int         lt;
        int         pk;
        int         lost;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int lost0;

        //          err    n   state lock_time peak lost
        vecs[0]  = '{8'd2,   15, 1, 15, 0,   0}; // 15 good samples
        vecs[1]  = '{8'd5,   1,  1, 16, 0,   0}; // just above LOCK_THRESH: restart
        vecs[2]  = '{8'hFD,  15, 1, 31, 0,   0}; // -3, 15 good
        vecs[3]  = '{8'd1,   1,  2, 32, 1,   0}; // 16th good -> LOCKED, peak loads
        vecs[4]  = '{8'd20,  3,  2, 32, 20,  0}; // 3 bad: stays locked
        vecs[5]  = '{8'd10,  1,  2, 32, 20,  0}; // hysteresis band clears bad count
        vecs[6]  = '{8'd20,  3,  2, 32, 20,  0};
        vecs[7]  = '{8'hE7,  1,  1, 32, 25,  1}; // -25, 4th bad -> ACQUIRE
        vecs[8]  = '{8'd0,   16, 2, 32, 0,   0}; // relock, lock_time holds
        vecs[9]  = '{8'h80,  1,  2, 32, 127, 0}; // most-negative saturates
        vecs[10] = '{8'd3,   1,  2, 32, 127, 0};

        rst_n  = 1'b0;
        enable = 1'b0;
        ref_in = 1'b0;
        err    = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_lock_lost", int'(lock_lost), 0);
        chk("reset_lock_time", int'(lock_time), 0);
        chk("reset_peak", int'(peak), 0);

        // Release reset with ref already high: no strobe may be seen.
        ref_in = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("release_state", int'(state), 1);
        chk("release_no_strobe", int'(lock_time), 0);

        for (int i = 0; i < 11; i++) begin
            lost0 = lost_cnt;
            run_periods(vecs[i].e, vecs[i].n);
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
            chk($sformatf("vec%0d_locked", i), int'(locked), (vecs[i].st == 2) ? 1 : 0);
            chk($sformatf("vec%0d_lock_time", i), int'(lock_time), vecs[i].lt);
            chk($sformatf("vec%0d_peak", i), int'(peak), vecs[i].pk);
            chk($sformatf("vec%0d_lost", i), lost_cnt - lost0, vecs[i].lost);
        end

        // Enable low forces IDLE on the next cycle and clears lock_time.
        enable = 1'b0;
        @(negedge clk);
        chk("disable_state", int'(state), 0);
        chk("disable_locked", int'(locked), 0);
        chk("disable_lock_time", int'(lock_time), 0);

        // Fresh acquire: locked_o rises one cycle after the 16th ref edge.
        enable = 1'b1;
        repeat (2) @(negedge clk);
        run_periods(8'd2, 15);
        ref_in = 1'b0;
        repeat (4) @(negedge clk);
        ref_in = 1'b1;
        @(negedge clk);
        chk("lat_not_yet_locked", int'(locked), 0);
        @(negedge clk);
        chk("lat_locked", int'(locked), 1);
        chk("lat_lock_time", int'(lock_time), 16);
        chk("lat_state", int'(state), 2);
        repeat (2) @(negedge clk);

        // Reference lost while locked.
        lost0  = lost_cnt;
        ref_in = 1'b0;
        repeat (900) @(negedge clk);
        chk("tmo_still_locked", int'(state), 2);
        for (int i = 0; i < 300 && state != 2'b11; i++) @(negedge clk);
        chk("tmo_ref_lost", int'(state), 3);
        repeat (2) @(negedge clk);
        chk("tmo_lost_pulse", lost_cnt - lost0, 1);
        ref_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("tmo_reacquire", int'(state), 1);

        // Relock, then assert reset asynchronously between clock edges.
        run_periods(8'd1, 16);
        chk("relock_state", int'(state), 2);
        chk("relock_peak", int'(peak), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_lock_lost", int'(lock_lost), 0);
        chk("async_rst_lock_time", int'(lock_time), 0);
        chk("async_rst_peak", int'(peak), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adpll_lock_detector.md
ADPLL_LOCK_DETECTOR -- requirements
Module: adpll_lock_detector

Interface
REQ-001 SHALL have parameter PDET_WIDTH, default 8: width of the signed phase-error input.
REQ-002 SHALL have parameter LOCK_THRESH, default 4: max |error| counted as in-lock.
REQ-003 SHALL have parameter UNLOCK_THRESH, default 16: |error| above this counts as out-of-lock.
REQ-004 SHALL have parameter LOCK_COUNT, default 16: consecutive good samples needed to declare lock.
REQ-005 SHALL have parameter UNLOCK_COUNT, default 4: consecutive bad samples needed to drop lock.
REQ-006 SHALL have parameter REF_TIMEOUT, default 1024: fpga_clk_i cycles without a ref edge before the reference is declared lost.
REQ-007 fpga_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-008 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-009 enable_i  input  1  detector enable; low forces IDLE.
REQ-010 ref_i  input  1  reference or divided ADPLL clock, already synchronised to fpga_clk_i.
REQ-011 error_i  input  PDET_WIDTH  signed two's-complement phase error from the NetworkADPLL phase detector.
REQ-012 locked_o  output  1  high while in LOCKED.
REQ-013 state_o  output  2  FSM state: 00 IDLE, 01 ACQUIRE, 10 LOCKED, 11 REF_LOST.
REQ-014 lock_lost_o  output  1  one-cycle pulse on LOCKED -> ACQUIRE or LOCKED -> REF_LOST.
REQ-015 lock_time_o  output  16  ref edges from enable to first lock, saturating.
REQ-016 peak_error_o  output  PDET_WIDTH-1  max |error| sampled since last entry to LOCKED.

Function
REQ-017 SHALL register ref_i each cycle; sample strobe = ref_i high and registered copy low (rising edge).
REQ-018 On strobe SHALL register |error_i|; most-negative input saturates to 2^(PDET_WIDTH-1)-1.
REQ-019 Latency: strobe at cycle N -> abs sample registered at N -> FSM, counters, outputs update at N+1.
REQ-020 IDLE: enable_i low SHALL force IDLE from any state next cycle; counters and lock_time_o cleared; enable_i high -> ACQUIRE.
REQ-021 ACQUIRE: good counter increments per sample with abs <= LOCK_THRESH, clears to 0 on any other sample; reaching LOCK_COUNT -> LOCKED, counter cleared.
REQ-022 LOCKED: bad counter increments per sample with abs > UNLOCK_THRESH, clears on sample with abs <= UNLOCK_THRESH; reaching UNLOCK_COUNT -> ACQUIRE with lock_lost_o pulse.
REQ-023 Samples with LOCK_THRESH < abs <= UNLOCK_THRESH SHALL not change state in LOCKED (hysteresis).
REQ-024 Timeout counter SHALL clear on every strobe and increment otherwise, saturating at REF_TIMEOUT; reaching REF_TIMEOUT in ACQUIRE or LOCKED -> REF_LOST (pulse lock_lost_o only if from LOCKED).
REQ-025 REF_LOST: next strobe -> ACQUIRE with good counter cleared; enable_i low still -> IDLE.
REQ-026 lock_time_o SHALL increment per strobe in ACQUIRE until first LOCKED entry after enable, then hold; saturate at 16'hFFFF.
REQ-027 peak_error_o SHALL load the current sample on LOCKED entry and update to max(peak, abs) on each subsequent strobe in LOCKED; hold otherwise.
REQ-028 Precedence within a cycle: enable_i low > timeout > sample evaluation.
REQ-029 Counters SHALL be wide enough for their parameter and never wrap.

Reset
REQ-030 rst_n_i low SHALL immediately force IDLE, locked_o 0, lock_lost_o 0, lock_time_o 0, peak_error_o 0, all counters and registered ref 0.
REQ-031 Release of rst_n_i mid-stream SHALL not create a strobe unless ref_i is seen low then high after release.

Verification
REQ-032 enable 1, error 2, ref period 8 clocks -> locked_o rises 1 cycle after 16th edge; lock_time_o = 16; state_o 10.
REQ-033 Locked; error 20 for 3 edges then 10 -> stays LOCKED; error 20 for 4 edges -> lock_lost_o one pulse, state_o 01.
REQ-034 ACQUIRE with 15 good samples then one error 5 -> counter restarts; lock needs 16 more good samples.
REQ-035 Locked; ref_i held low 1024 clocks -> state_o 11, lock_lost_o pulse; next ref edge -> state_o 01.
REQ-036 error_i = 8'h80 while LOCKED -> peak_error_o = 127; enable_i low -> state_o 00 next cycle, lock_time_o 0.
REQ-037 rst_n_i asserted asynchronously mid-LOCKED -> all outputs 0 before next clock edge.
